// File: rtl/user_event_gen.sv
`default_nettype none

// ============================================================================
// Package : user_event_pkg
// Description : Event codes exchanged between user_event_gen and the game logic.
// Revision : 1.0 - initial release
// ============================================================================
package user_event_pkg;

    typedef enum logic [2:0] {
        EV_DOWN     = 3'd0,
        EV_LEFT     = 3'd1,
        EV_RIGHT    = 3'd2,
        EV_ROTATE   = 3'd3,
        EV_NEW_GAME = 3'd4
    } user_event_t;

endpackage

// ============================================================================
// Module : user_event_gen
// Description : Turns raw player buttons and a gravity timer into a stream of
//               user_event_t codes delivered through a show-ahead FIFO.
//               Buttons are synchronised, debounced and edge-detected;
//               LEFT/RIGHT/DOWN auto-repeat while held. One pending flag per
//               source plus a fixed-priority arbiter guarantee that no event is
//               lost while the FIFO has room; repeated events on a source that
//               is still pending are coalesced and flagged on overflow_o.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i               in   system clock
//   rst_i               in   asynchronous reset, active-high
//   btn_left_i          in   raw button, active-high, asynchronous
//   btn_right_i         in   raw button
//   btn_down_i          in   raw button
//   btn_rotate_i        in   raw button
//   btn_new_game_i      in   raw button
//   gravity_en_i        in   1 = game running, gravity timer counts
//   user_event_o        out  FIFO head, valid while user_event_ready_o = 1
//   user_event_ready_o  out  FIFO not empty
//   user_event_rd_req_i in   consumer pop request
//   overflow_o          out  sticky, set when an event had to be coalesced
// ============================================================================
module user_event_gen
    import user_event_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int DEBOUNCE_TICKS = 50000,
    parameter int REPEAT_DELAY   = 10000000,
    parameter int REPEAT_PERIOD  = 2500000,
    parameter int GRAVITY_TICKS  = 25000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_left_i,
    input  logic        btn_right_i,
    input  logic        btn_down_i,
    input  logic        btn_rotate_i,
    input  logic        btn_new_game_i,
    input  logic        gravity_en_i,
    output user_event_t user_event_o,
    output logic        user_event_ready_o,
    input  logic        user_event_rd_req_i,
    output logic        overflow_o
);

    // Source indices; a lower index means higher arbitration priority.
    localparam int c_SRC_NEW_GAME = 0;
    localparam int c_SRC_ROTATE   = 1;
    localparam int c_SRC_LEFT     = 2;
    localparam int c_SRC_RIGHT    = 3;
    localparam int c_SRC_DOWN     = 4;
    localparam int c_SRC_GRAVITY  = 5;
    localparam int c_NUM_BTN      = 5;
    localparam int c_NUM_SRC      = 6;

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W  = $clog2(c_REP_MAX + 1);
    localparam int c_GRAV_W = $clog2(GRAVITY_TICKS + 1);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST        = c_DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [c_REP_W-1:0]  c_REP_DELAY_LOAD  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0]  c_REP_PERIOD_LOAD = c_REP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_GRAV_W-1:0] c_GRAV_LAST       = c_GRAV_W'(GRAVITY_TICKS - 1);

    // ------------------------------------------------------------------------
    // Button input path
    // ------------------------------------------------------------------------
    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] w_btn_press;
    logic [c_NUM_BTN-1:0] w_btn_repeat;

    assign w_btn_raw = {btn_down_i, btn_right_i, btn_left_i, btn_rotate_i, btn_new_game_i};

    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_d;
        logic [c_DEB_W-1:0] r_deb_cnt;

        // The debounce count measures consecutive cycles the synchronised
        // input disagrees with the accepted level; agreement restarts it.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                if (r_sync2 == r_level) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    r_level   <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end

        assign w_btn_press[gi] = r_level & ~r_level_d;

        if (gi >= c_SRC_LEFT) begin : g_repeat
            logic [c_REP_W-1:0] r_rep_cnt;

            // Down-counter loaded in the press cycle; reaching zero while the
            // button is still held fires a repeat and reloads the period.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_rep_cnt <= '0;
                end else if (!r_level) begin
                    r_rep_cnt <= '0;
                end else if (!r_level_d) begin
                    r_rep_cnt <= c_REP_DELAY_LOAD;
                end else if (r_rep_cnt == '0) begin
                    r_rep_cnt <= c_REP_PERIOD_LOAD;
                end else begin
                    r_rep_cnt <= r_rep_cnt - 1'b1;
                end
            end

            assign w_btn_repeat[gi] = r_level & r_level_d & (r_rep_cnt == '0);
        end else begin : g_no_repeat
            assign w_btn_repeat[gi] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Gravity timer
    // ------------------------------------------------------------------------
    logic [c_GRAV_W-1:0] r_grav_cnt;
    logic                w_grav_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grav_cnt <= '0;
        end else if (!gravity_en_i || (r_grav_cnt == c_GRAV_LAST)) begin
            r_grav_cnt <= '0;
        end else begin
            r_grav_cnt <= r_grav_cnt + 1'b1;
        end
    end

    assign w_grav_fire = gravity_en_i & (r_grav_cnt == c_GRAV_LAST);

    // ------------------------------------------------------------------------
    // FIFO status (needed by the arbiter)
    // ------------------------------------------------------------------------
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_pop   = user_event_rd_req_i & ~w_empty;

    // ------------------------------------------------------------------------
    // Pending flags and fixed-priority arbiter
    // ------------------------------------------------------------------------
    logic [c_NUM_SRC-1:0] r_pending;
    logic [c_NUM_SRC-1:0] w_src_event;
    logic [c_NUM_SRC-1:0] w_grant;
    logic [c_NUM_SRC-1:0] w_pending_nxt;
    logic                 w_wr_en;
    logic                 w_coalesce;
    user_event_t          w_wr_event;
    logic                 r_overflow;

    assign w_src_event = {w_grav_fire, w_btn_press | w_btn_repeat};

    // A full FIFO still accepts a write when the consumer pops in the same cycle.
    assign w_wr_en = (|r_pending) & (~w_full | w_pop);

    always_comb begin
        w_grant    = '0;
        w_wr_event = EV_DOWN;
        if (w_wr_en) begin
            if (r_pending[c_SRC_NEW_GAME]) begin
                w_grant[c_SRC_NEW_GAME] = 1'b1;
                w_wr_event              = EV_NEW_GAME;
            end else if (r_pending[c_SRC_ROTATE]) begin
                w_grant[c_SRC_ROTATE] = 1'b1;
                w_wr_event            = EV_ROTATE;
            end else if (r_pending[c_SRC_LEFT]) begin
                w_grant[c_SRC_LEFT] = 1'b1;
                w_wr_event          = EV_LEFT;
            end else if (r_pending[c_SRC_RIGHT]) begin
                w_grant[c_SRC_RIGHT] = 1'b1;
                w_wr_event           = EV_RIGHT;
            end else if (r_pending[c_SRC_DOWN]) begin
                w_grant[c_SRC_DOWN] = 1'b1;
                w_wr_event          = EV_DOWN;
            end else begin
                w_grant[c_SRC_GRAVITY] = 1'b1;
                w_wr_event             = EV_DOWN;
            end
        end
    end

    // A flag being granted this cycle is free to take a new event, so only a
    // flag that stays pending turns a new event into a coalesce.
    always_comb begin
        w_pending_nxt = (r_pending & ~w_grant) | w_src_event;
        if (!gravity_en_i) begin
            w_pending_nxt[c_SRC_GRAVITY] = 1'b0;
        end
    end

    assign w_coalesce = |(r_pending & ~w_grant & w_src_event);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_overflow <= r_overflow | w_coalesce;
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------------
    user_event_t r_mem [FIFO_DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= EV_DOWN;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_wr_event;
                r_wr_ptr                     <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign user_event_o       = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign user_event_ready_o = ~w_empty;
    assign overflow_o         = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_user_event_gen.sv
`default_nettype none

// ============================================================================
// Module : tb_user_event_gen
// Description : Directed, self-checking bench for user_event_gen using short
//               debounce / repeat / gravity periods. Cycle 0 is the cycle in
//               which a test first changes its inputs; outputs are sampled on
//               the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_event_gen;
    import user_event_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left;
    logic        btn_right;
    logic        btn_down;
    logic        btn_rotate;
    logic        btn_new_game;
    logic        gravity_en;
    logic        rd_req;
    user_event_t ev;
    logic        ready;
    logic        overflow;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Events consumed by the bench: the code and the cycle in which it was
    // presented with rd_req high (it leaves the FIFO on the next rising edge).
    user_event_t log_ev [$];
    int          log_cyc [$];

    always #5 clk = ~clk;

    user_event_gen #(
        .FIFO_DEPTH     (4),
        .DEBOUNCE_TICKS (4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .GRAVITY_TICKS  (16)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .btn_left_i          (btn_left),
        .btn_right_i         (btn_right),
        .btn_down_i          (btn_down),
        .btn_rotate_i        (btn_rotate),
        .btn_new_game_i      (btn_new_game),
        .gravity_en_i        (gravity_en),
        .user_event_o        (ev),
        .user_event_ready_o  (ready),
        .user_event_rd_req_i (rd_req),
        .overflow_o          (overflow)
    );

    // Called at a falling edge: log a pop that the next rising edge performs,
    // then advance to the following falling edge.
    task automatic tick();
        if (ready && rd_req) begin
            log_ev.push_back(ev);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_inputs();
        btn_left     = 1'b0;
        btn_right    = 1'b0;
        btn_down     = 1'b0;
        btn_rotate   = 1'b0;
        btn_new_game = 1'b0;
        gravity_en   = 1'b0;
        rd_req       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        log_ev.delete();
        log_cyc.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", ready); else passed++;
        checks++; if (ev !== EV_DOWN) $display("FAIL reset_event: got %0d want %0d", ev, EV_DOWN); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ready !== 1'b0) $display("FAIL idle_ready: got %0b want 0", ready); else passed++;
    endtask

    // Single RIGHT press released before the first repeat would fire.
    task automatic test_single_right();
        do_reset();
        btn_right = 1'b1;
        repeat (7) tick();
        checks++; if (ready !== 1'b0) $display("FAIL right_ready_c7: got %0b want 0", ready); else passed++;
        tick();
        checks++; if (ready !== 1'b1) $display("FAIL right_ready_c8: got %0b want 1", ready); else passed++;
        checks++; if (ev !== EV_RIGHT) $display("FAIL right_event_c8: got %0d want %0d", ev, EV_RIGHT); else passed++;
        repeat (10) tick();
        btn_right = 1'b0;
        rd_req    = 1'b1;
        repeat (30) tick();
        checks++; if (log_ev.size() !== 1) $display("FAIL right_count: got %0d want 1", log_ev.size()); else passed++;
        if (log_ev.size() > 0) begin
            checks++; if (log_ev[0] !== EV_RIGHT) $display("FAIL right_logged: got %0d want %0d", log_ev[0], EV_RIGHT); else passed++;
        end
        checks++; if (overflow !== 1'b0) $display("FAIL right_overflow: got %0b want 0", overflow); else passed++;
    endtask

    // Two 2-cycle glitches, then a stable level from cycle 8.
    task automatic test_glitch();
        logic [7:0] pat;
        pat = 8'b0011_0011;
        do_reset();
        rd_req = 1'b1;
        for (int c = 0; c < 50; c++) begin
            btn_left = (c < 8) ? pat[c] : (c < 20);
            tick();
        end
        checks++; if (log_ev.size() !== 1) $display("FAIL glitch_count: got %0d want 1", log_ev.size()); else passed++;
        if (log_ev.size() > 0) begin
            checks++; if (log_ev[0] !== EV_LEFT) $display("FAIL glitch_event: got %0d want %0d", log_ev[0], EV_LEFT); else passed++;
            checks++; if (log_cyc[0] !== 16) $display("FAIL glitch_cycle: got %0d want 16", log_cyc[0]); else passed++;
        end
    endtask

    // DOWN held for cycles 0..59: press at 6, repeats at 26,34,42,50,58,
    // each visible two cycles after its source cycle.
    task automatic test_repeat_down();
        int exp_cyc [6] = '{8, 28, 36, 44, 52, 60};
        do_reset();
        rd_req   = 1'b1;
        btn_down = 1'b1;
        repeat (60) tick();
        btn_down = 1'b0;
        repeat (40) tick();
        checks++; if (log_ev.size() !== 6) $display("FAIL repeat_count: got %0d want 6", log_ev.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            if (i < log_ev.size()) begin
                checks++; if (log_cyc[i] !== exp_cyc[i]) $display("FAIL repeat_cycle_%0d: got %0d want %0d", i, log_cyc[i], exp_cyc[i]); else passed++;
                checks++; if (log_ev[i] !== EV_DOWN) $display("FAIL repeat_event_%0d: got %0d want %0d", i, log_ev[i], EV_DOWN); else passed++;
            end
        end
    endtask

    // Gravity fires at cycles 15,31,47,63 (FIFO full), 79 (held pending),
    // 95 (coalesced -> overflow). One pop at cycle 100 admits the pending one.
    task automatic test_gravity_overflow();
        do_reset();
        gravity_en = 1'b1;
        repeat (90) tick();
        checks++; if (ready !== 1'b1) $display("FAIL grav_ready_c90: got %0b want 1", ready); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL grav_overflow_c90: got %0b want 0", overflow); else passed++;
        repeat (10) tick();
        checks++; if (overflow !== 1'b1) $display("FAIL grav_overflow_c100: got %0b want 1", overflow); else passed++;
        rd_req = 1'b1;
        tick();
        rd_req     = 1'b0;
        gravity_en = 1'b0;
        checks++; if (ready !== 1'b1) $display("FAIL grav_ready_after_pop: got %0b want 1", ready); else passed++;
        rd_req = 1'b1;
        repeat (10) tick();
        checks++; if (log_ev.size() !== 5) $display("FAIL grav_total_popped: got %0d want 5", log_ev.size()); else passed++;
        for (int i = 0; i < log_ev.size(); i++) begin
            checks++; if (log_ev[i] !== EV_DOWN) $display("FAIL grav_event_%0d: got %0d want %0d", i, log_ev[i], EV_DOWN); else passed++;
        end
        checks++; if (overflow !== 1'b1) $display("FAIL grav_overflow_sticky: got %0b want 1", overflow); else passed++;
    endtask

    task automatic test_priority();
        user_event_t exp_ev [3] = '{EV_NEW_GAME, EV_ROTATE, EV_RIGHT};
        int          exp_c  [3] = '{8, 9, 10};
        do_reset();
        rd_req       = 1'b1;
        btn_new_game = 1'b1;
        btn_rotate   = 1'b1;
        btn_right    = 1'b1;
        repeat (10) tick();
        btn_new_game = 1'b0;
        btn_rotate   = 1'b0;
        btn_right    = 1'b0;
        repeat (30) tick();
        checks++; if (log_ev.size() !== 3) $display("FAIL prio_count: got %0d want 3", log_ev.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < log_ev.size()) begin
                checks++; if (log_ev[i] !== exp_ev[i]) $display("FAIL prio_event_%0d: got %0d want %0d", i, log_ev[i], exp_ev[i]); else passed++;
                checks++; if (log_cyc[i] !== exp_c[i]) $display("FAIL prio_cycle_%0d: got %0d want %0d", i, log_cyc[i], exp_c[i]); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_new_game = 1'b1;
        btn_rotate   = 1'b1;
        btn_left     = 1'b1;
        repeat (10) tick();
        btn_new_game = 1'b0;
        btn_rotate   = 1'b0;
        btn_left     = 1'b0;
        repeat (2) tick();
        checks++; if (ready !== 1'b1) $display("FAIL midrst_ready_before: got %0b want 1", ready); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) $display("FAIL midrst_ready_async: got %0b want 0", ready); else passed++;
        checks++; if (ev !== EV_DOWN) $display("FAIL midrst_event_async: got %0d want %0d", ev, EV_DOWN); else passed++;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        rd_req = 1'b1;
        log_ev.delete();
        log_cyc.delete();
        repeat (30) tick();
        checks++; if (log_ev.size() !== 0) $display("FAIL midrst_spurious: got %0d events want 0", log_ev.size()); else passed++;
        cyc        = 0;
        btn_rotate = 1'b1;
        repeat (10) tick();
        btn_rotate = 1'b0;
        repeat (10) tick();
        checks++; if (log_ev.size() !== 1) $display("FAIL midrst_new_count: got %0d want 1", log_ev.size()); else passed++;
        if (log_ev.size() > 0) begin
            checks++; if (log_ev[0] !== EV_ROTATE) $display("FAIL midrst_new_event: got %0d want %0d", log_ev[0], EV_ROTATE); else passed++;
            checks++; if (log_cyc[0] !== 8) $display("FAIL midrst_new_cycle: got %0d want 8", log_cyc[0]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_right();
        test_glitch();
        test_repeat_down();
        test_gravity_overflow();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
